// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment pattern table, blank code and receiver state enum
package seg7_pkg;

  localparam logic [6:0] BLANK = 7'b1111111;

  // Active-low abcdefg patterns, index = hex value; the display driver uses the same table.
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    EMIT    = 2'd2,
    RELEASE = 2'd3
  } seg7_state_e;

  // Returns {err, hex}; an unknown pattern decodes to err=1, hex=0.
  function automatic logic [4:0] seg7_decode(input logic [6:0] pat);
    logic [4:0] r;
    r = 5'b10000;
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG7_TABLE[i]) r = {1'b0, 4'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_sync_filter.sv
// rtl/seg7_sync_filter.sv - two-flop synchronizer plus candidate/stability counter
module seg7_sync_filter
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  seg7_state_e state,
  output logic [6:0]  sync_o,
  output logic [6:0]  cand_o,
  output logic        stable_o
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [6:0]    sync1_q, sync2_q;
  logic [6:0]    cand_d, cand_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          sync_blank;
  logic          sync_match;

  assign sync_blank = (sync2_q == BLANK);
  assign sync_match = (sync2_q == cand_q);

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    case (state)
      IDLE: begin
        if (!sync_blank) begin
          cand_d = sync2_q;
          cnt_d  = '0;
        end
      end
      SETTLE: begin
        if (!sync_blank) begin
          if (!sync_match) begin
            cand_d = sync2_q;
            cnt_d  = '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RELEASE: begin
        if (!sync_blank && !sync_match) begin
          cand_d = sync2_q;
          cnt_d  = '0;
        end
      end
      default: begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= BLANK;
      sync2_q <= BLANK;
      cand_q  <= BLANK;
      cnt_q   <= '0;
    end else begin
      sync1_q <= seg_in;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter stops at CNT_MAX; the FSM leaves SETTLE on the same edge, so it never wraps.
  assign stable_o = (state == SETTLE) && !sync_blank && sync_match && (cnt_q == CNT_MAX);
  assign sync_o   = sync2_q;
  assign cand_o   = cand_q;

endmodule

// File: rtl/seg7_rx.sv
// rtl/seg7_rx.sv - seven-segment pattern receiver: decode, ready/valid handshake, digit history
module seg7_rx
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        CLOCK_50,
  input  logic        RST_N,
  input  logic [0:6]  SEG_IN,
  input  logic        READY,
  output logic        VALID,
  output logic [3:0]  HEX_VAL,
  output logic        ERR,
  output logic [15:0] DIGITS,
  output logic [2:0]  DIGIT_CNT
);

  logic [6:0]  seg_w;
  logic [6:0]  sync_w;
  logic [6:0]  cand_w;
  logic        stable_w;
  logic [4:0]  dec_w;

  seg7_state_e state_d, state_q;
  logic        valid_d, valid_q;
  logic [3:0]  hex_d, hex_q;
  logic        err_d, err_q;
  logic [15:0] digits_d, digits_q;
  logic [2:0]  dcnt_d, dcnt_q;

  assign seg_w = SEG_IN;

  seg7_sync_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk      (CLOCK_50),
    .rst_n    (RST_N),
    .seg_in   (seg_w),
    .state    (state_q),
    .sync_o   (sync_w),
    .cand_o   (cand_w),
    .stable_o (stable_w)
  );

  assign dec_w = seg7_decode(cand_w);

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    hex_d    = hex_q;
    err_d    = err_q;
    digits_d = digits_q;
    dcnt_d   = dcnt_q;
    case (state_q)
      IDLE: begin
        if (sync_w != BLANK) state_d = SETTLE;
      end
      SETTLE: begin
        if (sync_w == BLANK) begin
          state_d = IDLE;
        end else if (stable_w) begin
          state_d = EMIT;
          valid_d = 1'b1;
          err_d   = dec_w[4];
          hex_d   = dec_w[3:0];
        end
      end
      EMIT: begin
        // SEG_IN is ignored here; the held value stays put until the consumer takes it.
        if (valid_q && READY) begin
          state_d = RELEASE;
          valid_d = 1'b0;
          err_d   = 1'b0;
          if (!err_q) begin
            digits_d = {digits_q[11:0], hex_q};
            if (dcnt_q != 3'd4) dcnt_d = dcnt_q + 3'd1;
          end
        end
      end
      RELEASE: begin
        if (sync_w == BLANK) begin
          state_d = IDLE;
        end else if (sync_w != cand_w) begin
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      hex_q    <= 4'd0;
      err_q    <= 1'b0;
      digits_q <= 16'd0;
      dcnt_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      hex_q    <= hex_d;
      err_q    <= err_d;
      digits_q <= digits_d;
      dcnt_q   <= dcnt_d;
    end
  end

  assign VALID     = valid_q;
  assign HEX_VAL   = hex_q;
  assign ERR       = err_q;
  assign DIGITS    = digits_q;
  assign DIGIT_CNT = dcnt_q;

endmodule
